// File: rtl/lsb_embed_engine.sv
// LSB steganography engine: masters the pl_* BRAM port, hiding message bits in pixel-byte
// LSBs (EMBED) or gathering those LSBs back into message words (EXTRACT).
module lsb_embed_engine #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_BYTES  = 4,
   parameter int unsigned LEN_WIDTH  = 20
) (
   input  logic                  pl_clk,
   input  logic                  pl_rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] img_base,
   input  logic [ADDR_WIDTH-1:0] msg_base,
   input  logic [LEN_WIDTH-1:0]  msg_bits,
   output logic                  busy,
   output logic                  done,
   output logic                  pl_en,
   output logic [NUM_BYTES-1:0]  pl_we,
   output logic [ADDR_WIDTH-1:0] pl_addr,
   output logic [DATA_WIDTH-1:0] pl_din,
   input  logic [DATA_WIDTH-1:0] pl_dout
);

   // Bit index of the current pixel's byte 0; wide enough to step past L without overflow.
   localparam int unsigned KW = LEN_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_MSG_RD, S_MSG_WT, S_PIX_RD, S_PIX_WT, S_PIX_WR, S_MSG_WR, S_DONE
   } state_t;

   state_t                state_q;
   logic                  mode_q, busy_q, done_q, pl_en_q;
   logic [NUM_BYTES-1:0]  pl_we_q;
   logic [ADDR_WIDTH-1:0] img_base_q, msg_base_q, pl_addr_q;
   logic [DATA_WIDTH-1:0] pl_din_q, msg_sr_q, acc_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [KW-1:0]         k_q;

   logic [KW-1:0]         k_nxt, len_x;
   logic                  last_c;
   logic [ADDR_WIDTH-1:0] pix_addr_cur, pix_addr_nxt, msg_addr_cur, msg_addr_nxt;
   logic [DATA_WIDTH-1:0] pix_d, acc_d;

   assign busy    = busy_q;
   assign done    = done_q;
   assign pl_en   = pl_en_q;
   assign pl_we   = pl_we_q;
   assign pl_addr = pl_addr_q;
   assign pl_din  = pl_din_q;

   // Pixel address is img_base + k (4 bits per 4-byte word); message word is k/32.
   assign k_nxt        = k_q + KW'(4);
   assign len_x        = KW'(len_q);
   assign last_c       = (k_nxt >= len_x);
   assign pix_addr_cur = img_base_q + ADDR_WIDTH'(k_q);
   assign pix_addr_nxt = img_base_q + ADDR_WIDTH'(k_nxt);
   assign msg_addr_cur = msg_base_q + (ADDR_WIDTH'(k_q >> 5) << 2);
   assign msg_addr_nxt = msg_base_q + (ADDR_WIDTH'(k_nxt >> 5) << 2);

   // Embedded pixel and updated accumulator for the word on pl_dout; bytes past L untouched.
   always_comb begin
      pix_d = pl_dout;
      acc_d = acc_q;
      for (int j = 0; j < 4; j++) begin
         if ((k_q + KW'(j)) < len_x) begin
            pix_d[5'(8 * j)]           = msg_sr_q[5'(j)];
            acc_d[{k_q[4:2], 2'(j)}] = pl_dout[5'(8 * j)];
         end
      end
   end

   always_ff @(posedge pl_clk or posedge pl_rst) begin
      if (pl_rst) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pl_en_q    <= 1'b0;
         pl_we_q    <= '0;
         pl_addr_q  <= '0;
         pl_din_q   <= '0;
         img_base_q <= '0;
         msg_base_q <= '0;
         len_q      <= '0;
         k_q        <= '0;
         msg_sr_q   <= '0;
         acc_q      <= '0;
      end else begin
         done_q  <= 1'b0;
         pl_en_q <= 1'b0;
         pl_we_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q     <= mode;
                  img_base_q <= img_base;
                  msg_base_q <= msg_base;
                  len_q      <= msg_bits;
                  k_q        <= '0;
                  acc_q      <= '0;
                  busy_q     <= 1'b1;
                  if (msg_bits == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else if (!mode) begin
                     state_q   <= S_MSG_RD;
                     pl_en_q   <= 1'b1;
                     pl_addr_q <= msg_base;
                  end else begin
                     state_q   <= S_PIX_RD;
                     pl_en_q   <= 1'b1;
                     pl_addr_q <= img_base;
                  end
               end
            end
            S_MSG_RD: state_q <= S_MSG_WT;
            S_MSG_WT: begin
               msg_sr_q  <= pl_dout;
               state_q   <= S_PIX_RD;
               pl_en_q   <= 1'b1;
               pl_addr_q <= pix_addr_cur;
            end
            S_PIX_RD: state_q <= S_PIX_WT;
            S_PIX_WT: begin
               pl_en_q <= 1'b1;
               if (!mode_q) begin
                  // pl_addr still holds this pixel's address for the write-back
                  pl_din_q <= pix_d;
                  pl_we_q  <= '1;
                  msg_sr_q <= msg_sr_q >> 4;
                  state_q  <= S_PIX_WR;
               end else begin
                  k_q   <= k_nxt;
                  acc_q <= acc_d;
                  if (last_c || (k_nxt[4:0] == 5'd0)) begin
                     pl_we_q   <= '1;
                     pl_din_q  <= acc_d;
                     pl_addr_q <= msg_addr_cur;
                     state_q   <= S_MSG_WR;
                  end else begin
                     pl_addr_q <= pix_addr_nxt;
                     state_q   <= S_PIX_RD;
                  end
               end
            end
            S_PIX_WR: begin
               k_q <= k_nxt;
               if (last_c) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (k_nxt[4:0] == 5'd0) begin
                  state_q   <= S_MSG_RD;
                  pl_en_q   <= 1'b1;
                  pl_addr_q <= msg_addr_nxt;
               end else begin
                  state_q   <= S_PIX_RD;
                  pl_en_q   <= 1'b1;
                  pl_addr_q <= pix_addr_nxt;
               end
            end
            S_MSG_WR: begin
               acc_q <= '0;
               if (k_q >= len_x) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q   <= S_PIX_RD;
                  pl_en_q   <= 1'b1;
                  pl_addr_q <= pix_addr_cur;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
